neureka_outfeat_serializer: RTL and testbench
=============================================

// Module: neureka_outfeat_serializer
// PURPOSE
//  Parallel-in / serial-out output-feature buffer, the transmit-side counterpart of the infeat load path.
//  Captures one full tile (NW words of BLOCK_SIZE*DW bits) in a single handshake from the accumulator side.
//  Streams the tile out one DS-bit word per handshake towards the streamer/TCDM store path.
//  Words flagged as implicit padding go out with data and strobe all zero, so store addressing stays regular.
// PARAMETERS
//  NW          32  number of DS-bit words per tile (power of 2, >=2)
//  BLOCK_SIZE  32  bytes/lanes per word
//  DW          8   bits per lane; DS = DW*BLOCK_SIZE, AW = $clog2(NW)
// PORTS
//  clk_i        in   1        clock
//  rst_i        in   1        synchronous active-high reset
//  enable_i     in   1        0 = freeze FSM/counters; in_ready_o = out_valid_o = 0
//  clear_i      in   1        synchronous soft clear, same effect as rst_i
//  start_i      in   1        one-cycle pulse: arm a store of store_len_i words
//  store_len_i  in   AW+1     words to emit, 0..NW (sampled on accepted start_i)
//  pad_mask_i   in   NW       bit k=1: word k is emitted as padding (sampled with start_i)
//  in_valid_i   in   1        wide tile valid
//  in_ready_o   out  1        wide tile ready
//  in_data_i    in   NW*DS    tile; word k = in_data_i[(k+1)*DS-1 : k*DS]
//  out_valid_o  out  1        stream valid
//  out_ready_i  in   1        stream ready
//  out_data_o   out  DS       stream data
//  out_strb_o   out  DS/8     stream byte strobe
//  state_o      out  2        0 IDLE, 1 CAPTURE, 2 STREAM
//  cnt_o        out  AW       index of the word currently presented
//  done_o       out  1        one-cycle pulse after the last word is accepted
// BEHAVIOUR
//  Reset/clear: state IDLE, cnt 0, len 0, mask 0, buffer 0, done_o 0, in_ready_o 0, out_valid_o 0, out_strb_o 0.
//  IDLE: start_i & enable_i -> latch len = min(store_len_i, NW) and mask.
//    Then go to CAPTURE, or stay in IDLE and pulse done_o next cycle if len == 0.
//  CAPTURE: in_ready_o = 1. On in_valid_i & in_ready_o, register all NW words and go to STREAM, cnt = 0.
//  STREAM: out_valid_o = 1.
//    out_data_o = mask[cnt] ? '0 : buf[cnt]; out_strb_o = mask[cnt] ? '0 : '1.
//    On out_valid_o & out_ready_i: if cnt == len-1, go to IDLE, cnt = 0, done_o = 1 next cycle; else cnt++.
//  Registered outputs: first word is valid the cycle after capture (latency 1); then one word per cycle at full throughput.
//  start_i outside IDLE is ignored; so is in_valid_i outside CAPTURE.
//  Once asserted, out_valid_o holds and out_data_o/out_strb_o stay stable until the handshake.
//    Only enable_i=0, clear_i or rst_i override this.
//  enable_i = 0: all state holds; in_ready_o and out_valid_o are forced 0; no handshake can complete.
//  Priority: rst_i > clear_i > enable_i; clear_i mid-STREAM drops the remaining words, no done_o.
//  Outside STREAM: out_data_o = buf[cnt], out_strb_o = 0 (contents don't care).
//  store_len_i > NW saturates to NW; cnt never exceeds NW-1.
// CONFIGURATION
//  NEUREKA_OUTFEAT_SER_PERF_EN defined: adds port stall_cnt_o (out, 32).
//    Counts cycles with out_valid_o & ~out_ready_i; saturates at 2^32-1.
//    Cleared by rst_i/clear_i and by an accepted start_i; holds when enable_i = 0.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  T1 full tile: len=32, mask=0, word k = {32{8'(k)}}, out_ready_i=1 -> 32 words k=0..31 on consecutive cycles, strb all 1, done_o 1 cycle.
//  T2 padding: len=4, mask=32'h0000_000A -> words 0,2 = data; words 1,3 = data 0 and strb 0; done_o after the 4th word.
//  T3 backpressure: len=3, out_ready_i toggling 1010... -> data/strb stable while stalled; 3 handshakes in total.
//    With PERF_EN: stall_cnt_o = 2.
//  T4 boundaries: len=0 -> no in_ready_o, done_o 1 cycle after start; len=40 -> exactly 32 words; start_i mid-STREAM -> ignored.
//  T5 clear/enable: clear_i at cnt=5 of len=16 -> IDLE next cycle, no done_o.
//    enable_i=0 for 3 cycles mid-STREAM -> out_valid_o 0, cnt held, stream resumes at same word.
//  T6 reset: rst_i during CAPTURE with in_valid_i=1 -> no capture; all outputs at reset values next cycle.

Source files
------------

// File: rtl/neureka_outfeat_serializer.sv
// -----------------------------------------------------------------------------
// neureka_outfeat_serializer
//
// Purpose:
//   Parallel-in / serial-out output-feature buffer. A whole tile of NW words
//   (each DS = BLOCK_SIZE*DW bits) is captured in a single wide handshake from
//   the accumulator side. The tile is then streamed out one DS-bit word per
//   handshake towards the store path. Words flagged in the pad mask are still
//   emitted, but with data and strobe forced to zero. This keeps the store
//   addressing regular.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   enable_i     0 freezes all state and blocks both handshakes
//   clear_i      synchronous soft clear (same effect as rst_i)
//   start_i      one-cycle pulse arming a store of store_len_i words
//   store_len_i  words to emit (0..NW, larger values saturate to NW)
//   pad_mask_i   bit k = 1 -> word k is emitted as padding
//   in_valid_i / in_ready_o / in_data_i    wide tile handshake
//   out_valid_o / out_ready_i / out_data_o / out_strb_o   word stream
//   state_o      0 IDLE, 1 CAPTURE, 2 STREAM
//   cnt_o        index of the word currently presented
//   done_o       one-cycle pulse after the last word is accepted
//   stall_cnt_o  (only with NEUREKA_OUTFEAT_SER_PERF_EN) stalled-output cycles
//
// Configuration macro:
//   NEUREKA_OUTFEAT_SER_PERF_EN  adds stall_cnt_o, a saturating 32-bit count
//                                of cycles with out_valid_o & ~out_ready_i.
// -----------------------------------------------------------------------------
module neureka_outfeat_serializer #(
    parameter int unsigned NW         = 32,
    parameter int unsigned BLOCK_SIZE = 32,
    parameter int unsigned DW         = 8,
    localparam int unsigned DS        = DW * BLOCK_SIZE,
    localparam int unsigned AW        = $clog2(NW)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [AW:0]       store_len_i,
    input  logic [NW-1:0]     pad_mask_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [NW*DS-1:0]  in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DS-1:0]     out_data_o,
    output logic [DS/8-1:0]   out_strb_o,
    output logic [1:0]        state_o,
    output logic [AW-1:0]     cnt_o,
`ifdef NEUREKA_OUTFEAT_SER_PERF_EN
    output logic [31:0]       stall_cnt_o,
`endif
    output logic              done_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_STREAM  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            r_state;
    logic [AW-1:0]     r_cnt;
    logic [AW:0]       r_len;
    logic [NW-1:0]     r_mask;
    logic              r_done;
    logic [DS-1:0]     r_buf [NW];

    state_t            w_state_next;
    logic [AW-1:0]     w_cnt_next;
    logic [AW:0]       w_len_next;
    logic [NW-1:0]     w_mask_next;
    logic              w_done_next;
    logic              w_capture;
    logic              w_start_acc;

    logic [AW:0]       w_len_sat;
    logic              w_last;
    logic              w_cur_pad;
    logic [DS-1:0]     w_cur_word;
    logic              w_soft_rst;

    assign w_soft_rst = rst_i | clear_i;

    // Requests longer than a tile are clipped so cnt can never run past NW-1.
    assign w_len_sat = (store_len_i > (AW+1)'(NW)) ? (AW+1)'(NW) : store_len_i;

    // r_len is at least 1 whenever STREAM is reached, so len-1 cannot wrap.
    assign w_last = ({1'b0, r_cnt} == (r_len - (AW+1)'(1)));

    assign w_cur_word = r_buf[r_cnt];
    assign w_cur_pad  = r_mask[r_cnt];

    // -------------------------------------------------------------------------
    // Handshake and data outputs
    // -------------------------------------------------------------------------
    // Only the handshake qualifiers are gated by enable_i. Data and strobe keep
    // reflecting the held state, so the word is still there on resume.
    assign in_ready_o  = enable_i && (r_state == ST_CAPTURE);
    assign out_valid_o = enable_i && (r_state == ST_STREAM);

    assign out_data_o  = ((r_state == ST_STREAM) && w_cur_pad)  ? '0 : w_cur_word;
    assign out_strb_o  = ((r_state == ST_STREAM) && !w_cur_pad) ? '1 : '0;

    assign state_o = r_state;
    assign cnt_o   = r_cnt;
    assign done_o  = r_done;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_len_next   = r_len;
        w_mask_next  = r_mask;
        w_done_next  = 1'b0;
        w_capture    = 1'b0;
        w_start_acc  = 1'b0;

        if (enable_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        w_start_acc = 1'b1;
                        w_len_next  = w_len_sat;
                        w_mask_next = pad_mask_i;
                        w_cnt_next  = '0;
                        // An empty store has nothing to capture; it completes
                        // immediately with the usual one-cycle done pulse.
                        if (w_len_sat == '0) begin
                            w_done_next = 1'b1;
                        end else begin
                            w_state_next = ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (in_valid_i) begin
                        w_capture    = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (out_ready_i) begin
                        if (w_last) begin
                            w_cnt_next   = '0;
                            w_done_next  = 1'b1;
                            w_state_next = ST_IDLE;
                        end else begin
                            w_cnt_next = r_cnt + AW'(1);
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_soft_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_mask  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_len   <= w_len_next;
            r_mask  <= w_mask_next;
            r_done  <= w_done_next;
        end
    end

    // -------------------------------------------------------------------------
    // Tile buffer: every word is loaded in the same cycle, so this is a
    // register file with a mux read, not a single-port RAM.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_buf
            always_ff @(posedge clk_i) begin
                if (w_soft_rst) begin
                    r_buf[gi] <= '0;
                end else if (w_capture) begin
                    r_buf[gi] <= in_data_i[gi*DS +: DS];
                end
            end
        end
    endgenerate

`ifdef NEUREKA_OUTFEAT_SER_PERF_EN
    // -------------------------------------------------------------------------
    // Stall counter. out_valid_o is already low while disabled, so the count
    // holds then without extra gating.
    // -------------------------------------------------------------------------
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (w_soft_rst) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if (out_valid_o && !out_ready_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_neureka_outfeat_serializer.sv
module tb_neureka_outfeat_serializer;

    localparam int unsigned NW         = 32;
    localparam int unsigned BLOCK_SIZE = 32;
    localparam int unsigned DW         = 8;
    localparam int unsigned DS         = DW * BLOCK_SIZE;
    localparam int unsigned AW         = $clog2(NW);

    logic              clk;
    logic              rst_i;
    logic              enable_i;
    logic              clear_i;
    logic              start_i;
    logic [AW:0]       store_len_i;
    logic [NW-1:0]     pad_mask_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [NW*DS-1:0]  in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DS-1:0]     out_data_o;
    logic [DS/8-1:0]   out_strb_o;
    logic [1:0]        state_o;
    logic [AW-1:0]     cnt_o;
    logic              done_o;
`ifdef NEUREKA_OUTFEAT_SER_PERF_EN
    logic [31:0]       stall_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    neureka_outfeat_serializer #(
        .NW         (NW),
        .BLOCK_SIZE (BLOCK_SIZE),
        .DW         (DW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .start_i     (start_i),
        .store_len_i (store_len_i),
        .pad_mask_i  (pad_mask_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_strb_o  (out_strb_o),
        .state_o     (state_o),
        .cnt_o       (cnt_o),
`ifdef NEUREKA_OUTFEAT_SER_PERF_EN
        .stall_cnt_o (stall_cnt_o),
`endif
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Word k of a tile generated with seed s: every byte equals k+s.
    function automatic logic [DS-1:0] exp_word(input int k, input int s);
        logic [DS-1:0] w;
        for (int b = 0; b < DS/8; b++) w[b*8 +: 8] = 8'(k + s);
        return w;
    endfunction

    function automatic logic [NW*DS-1:0] make_tile(input int s);
        logic [NW*DS-1:0] t;
        for (int k = 0; k < NW; k++) t[k*DS +: DS] = exp_word(k, s);
        return t;
    endfunction

    task automatic do_start(input int len, input logic [NW-1:0] mask);
        start_i     = 1'b1;
        store_len_i = (AW+1)'(len);
        pad_mask_i  = mask;
        cyc();
        start_i     = 1'b0;
    endtask

    task automatic do_capture(input int s);
        in_valid_i = 1'b1;
        in_data_i  = make_tile(s);
        cyc();
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cyc();
        cyc();
        rst_i = 1'b0;
        #1;
        checks++;
        if (state_o !== 2'd0 || cnt_o !== '0 || done_o !== 1'b0 || in_ready_o !== 1'b0 ||
            out_valid_o !== 1'b0 || out_strb_o !== '0 || out_data_o !== '0) begin
            errors++;
            $display("FAIL reset_state: state=%0d cnt=%0d done=%b ird=%b ovl=%b strb_zero=%b data_zero=%b, required 0/0/0/0/0/1/1",
                     state_o, cnt_o, done_o, in_ready_o, out_valid_o, out_strb_o == '0, out_data_o == '0);
        end
        $display("reset: state=%0d cnt=%0d", state_o, cnt_o);
    endtask

    task automatic test_full_tile();
        out_ready_i = 1'b1;
        do_start(32, '0);
        checks++;
        if (state_o !== 2'd1 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_capture_state: state=%0d in_ready=%b, required 1/1", state_o, in_ready_o);
        end
        do_capture(0);
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (out_valid_o !== 1'b1 || cnt_o !== AW'(k) || out_data_o !== exp_word(k, 0) ||
                out_strb_o !== '1 || done_o !== 1'b0) begin
                errors++;
                $display("FAIL full_word%0d: valid=%b cnt=%0d byte0=%h strb_all=%b done=%b, required 1/%0d/%h/1/0",
                         k, out_valid_o, cnt_o, out_data_o[7:0], out_strb_o == '1, done_o, k, 8'(k));
            end
            $display("full: word %0d byte0=%h", k, out_data_o[7:0]);
            cyc();
        end
        checks++;
        if (done_o !== 1'b1 || state_o !== 2'd0 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL full_done: done=%b state=%0d valid=%b, required 1/0/0", done_o, state_o, out_valid_o);
        end
        cyc();
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL full_done_pulse: done=%b, required 0", done_o);
        end
    endtask

    task automatic test_padding();
        logic [NW-1:0] mask;
        mask = 32'h0000_000A;
        out_ready_i = 1'b1;
        do_start(4, mask);
        do_capture(8'h40);
        for (int k = 0; k < 4; k++) begin
            logic [DS-1:0]   ed;
            logic [DS/8-1:0] es;
            ed = mask[k] ? '0 : exp_word(k, 8'h40);
            es = mask[k] ? '0 : '1;
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== ed || out_strb_o !== es || done_o !== 1'b0) begin
                errors++;
                $display("FAIL pad_word%0d: valid=%b byte0=%h strb0=%h done=%b, required 1/%h/%h/0",
                         k, out_valid_o, out_data_o[7:0], out_strb_o[3:0], done_o, ed[7:0], es[3:0]);
            end
            $display("pad: word %0d byte0=%h strb0=%h", k, out_data_o[7:0], out_strb_o[3:0]);
            cyc();
        end
        checks++;
        if (done_o !== 1'b1 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL pad_done: done=%b state=%0d, required 1/0", done_o, state_o);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        int k;
        int hs;
        k  = 0;
        hs = 0;
        do_start(3, '0);
        do_capture(8'h80);
`ifdef NEUREKA_OUTFEAT_SER_PERF_EN
        checks++;
        if (stall_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL bp_stall_start: stall_cnt=%0d, required 0", stall_cnt_o);
        end
`endif
        for (int i = 0; i < 5; i++) begin
            out_ready_i = (i % 2 == 0);
            #1;
            checks++;
            if (out_valid_o !== 1'b1 || cnt_o !== AW'(k) || out_data_o !== exp_word(k, 8'h80) ||
                out_strb_o !== '1 || done_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_cycle%0d: valid=%b cnt=%0d byte0=%h done=%b, required 1/%0d/%h/0",
                         i, out_valid_o, cnt_o, out_data_o[7:0], done_o, k, 8'(k + 8'h80));
            end
            $display("bp: cycle %0d ready=%b cnt=%0d byte0=%h", i, out_ready_i, cnt_o, out_data_o[7:0]);
            if (out_ready_i) begin
                k++;
                hs++;
            end
            cyc();
        end
        checks++;
        if (done_o !== 1'b1 || state_o !== 2'd0 || hs != 3) begin
            errors++;
            $display("FAIL bp_done: done=%b state=%0d handshakes=%0d, required 1/0/3", done_o, state_o, hs);
        end
`ifdef NEUREKA_OUTFEAT_SER_PERF_EN
        checks++;
        if (stall_cnt_o !== 32'd2) begin
            errors++;
            $display("FAIL bp_stall_cnt: stall_cnt=%0d, required 2", stall_cnt_o);
        end
`endif
        out_ready_i = 1'b1;
        cyc();
    endtask

    task automatic test_boundaries();
        int  words;
        bit  seen_done;
        bit  bad_data;
        // len = 0: completes straight from IDLE.
        do_start(0, '0);
        checks++;
        if (state_o !== 2'd0 || in_ready_o !== 1'b0 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL len0: state=%0d in_ready=%b done=%b, required 0/0/1", state_o, in_ready_o, done_o);
        end
        $display("len0: state=%0d done=%b", state_o, done_o);
        cyc();
        // in_valid_i in IDLE is ignored.
        in_valid_i = 1'b1;
        in_data_i  = make_tile(8'h11);
        #1;
        checks++;
        if (in_ready_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_in_valid: in_ready=%b done=%b, required 0/0", in_ready_o, done_o);
        end
        cyc();
        in_valid_i = 1'b0;
        checks++;
        if (state_o !== 2'd0) begin
            errors++;
            $display("FAIL idle_in_valid_state: state=%0d, required 0", state_o);
        end
        // len = 40 saturates to 32; a start pulse mid-stream is ignored.
        out_ready_i = 1'b1;
        do_start(40, '0);
        do_capture(8'h20);
        words     = 0;
        seen_done = 0;
        bad_data  = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid_o) begin
                if (out_data_o !== exp_word(words, 8'h20)) bad_data = 1;
                words++;
            end
            start_i     = (i == 3);
            store_len_i = 6'd2;
            cyc();
            start_i = 1'b0;
            if (done_o) begin
                seen_done = 1;
                break;
            end
        end
        $display("len40: words=%0d done=%b", words, seen_done);
        checks++;
        if (words != 32 || !seen_done || bad_data || state_o !== 2'd0) begin
            errors++;
            $display("FAIL len40_sat: words=%0d done_seen=%b bad_data=%b state=%0d, required 32/1/0/0",
                     words, seen_done, bad_data, state_o);
        end
        cyc();
    endtask

    task automatic test_clear_enable();
        out_ready_i = 1'b1;
        do_start(16, '0);
        do_capture(8'h30);
        for (int k = 0; k < 5; k++) cyc();
        checks++;
        if (cnt_o !== AW'(5) || out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL clear_pre: cnt=%0d valid=%b, required 5/1", cnt_o, out_valid_o);
        end
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        checks++;
        if (state_o !== 2'd0 || out_valid_o !== 1'b0 || cnt_o !== '0 || out_strb_o !== '0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_post: state=%0d valid=%b cnt=%0d strb_zero=%b done=%b, required 0/0/0/1/0",
                     state_o, out_valid_o, cnt_o, out_strb_o == '0, done_o);
        end
        $display("clear: state=%0d cnt=%0d", state_o, cnt_o);
        cyc();
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_no_done: done=%b, required 0", done_o);
        end
        // enable_i low for three cycles while word 2 is presented.
        do_start(8, '0);
        do_capture(8'h50);
        cyc();
        cyc();
        enable_i = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || cnt_o !== AW'(2) || state_o !== 2'd2) begin
                errors++;
                $display("FAIL enable_hold%0d: valid=%b in_ready=%b cnt=%0d state=%0d, required 0/0/2/2",
                         i, out_valid_o, in_ready_o, cnt_o, state_o);
            end
            $display("disabled: cycle %0d cnt=%0d", i, cnt_o);
            cyc();
        end
        enable_i = 1'b1;
        #1;
        for (int k = 2; k < 8; k++) begin
            checks++;
            if (out_valid_o !== 1'b1 || cnt_o !== AW'(k) || out_data_o !== exp_word(k, 8'h50)) begin
                errors++;
                $display("FAIL enable_resume%0d: valid=%b cnt=%0d byte0=%h, required 1/%0d/%h",
                         k, out_valid_o, cnt_o, out_data_o[7:0], k, 8'(k + 8'h50));
            end
            $display("resume: word %0d byte0=%h", k, out_data_o[7:0]);
            cyc();
        end
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL enable_done: done=%b, required 1", done_o);
        end
        cyc();
    endtask

    task automatic test_reset_capture();
        do_start(4, '0);
        in_valid_i = 1'b1;
        in_data_i  = make_tile(8'h70);
        rst_i      = 1'b1;
        cyc();
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        #1;
        checks++;
        if (state_o !== 2'd0 || cnt_o !== '0 || done_o !== 1'b0 || in_ready_o !== 1'b0 ||
            out_valid_o !== 1'b0 || out_strb_o !== '0 || out_data_o !== '0) begin
            errors++;
            $display("FAIL reset_capture: state=%0d cnt=%0d done=%b ird=%b ovl=%b strb_zero=%b data_zero=%b, required 0/0/0/0/0/1/1",
                     state_o, cnt_o, done_o, in_ready_o, out_valid_o, out_strb_o == '0, out_data_o == '0);
        end
        $display("reset_capture: state=%0d", state_o);
    endtask

    initial begin
        rst_i       = 1'b1;
        enable_i    = 1'b1;
        clear_i     = 1'b0;
        start_i     = 1'b0;
        store_len_i = '0;
        pad_mask_i  = '0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;

        test_reset();
        test_full_tile();
        test_padding();
        test_backpressure();
        test_boundaries();
        test_clear_enable();
        test_reset_capture();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
